// File: rtl/usb_arb_pkg.sv
// usb_arb_pkg: shared state type, buffer widths and round-robin helper for the bulk-IN arbiter
package usb_arb_pkg;
  localparam int BUF_ADDR_W = 9;
  localparam int BUF_LEN_W  = 10;
  typedef enum logic [2:0] {IDLE, WAIT_RDY, DATA, COMMIT, WAIT_ACK} state_t;
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/usb_rr_arbiter.sv
// usb_rr_arbiter: one-hot round-robin search from a registered start pointer
module usb_rr_arbiter import usb_arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          upd,
  input  logic [IW-1:0] upd_idx,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          hit
);
  logic [IW-1:0] ptr_q, ptr_d, j;
  always_comb begin
    gnt  = '0;
    gidx = '0;
    hit  = 1'b0;
    j    = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_q) + i) % N);
      if (en && !hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        gidx   = j;
      end
    end
    ptr_d = upd ? IW'(rr_next(int'(upd_idx), N)) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: round-robin sharing of the USB bulk-IN endpoint buffer among byte-stream packet sources
module usb_in_arbiter import usb_arb_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PKT     = 512,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  ext_clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ-1:0]    req_nodata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  pkt_done,
  output logic                  err_overlen,
  output logic                  err_ack_timeout,
  output logic [BUF_ADDR_W-1:0] buf_in_addr,
  output logic [7:0]            buf_in_data,
  output logic                  buf_in_wren,
  input  logic                  buf_in_ready,
  output logic                  buf_in_commit,
  output logic [BUF_LEN_W-1:0]  buf_in_commit_len,
  input  logic                  buf_in_commit_ack
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d, arb_gnt;
  logic [IW-1:0]         gidx_q, gidx_d, arb_idx;
  logic [BUF_LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
  logic [BUF_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d, bsel;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic wren_q, wren_d, commit_q, commit_d, done_q, done_d, ovl_q, ovl_d, tmo_q, tmo_d;
  logic ack_hi_q, ack_hi_d, arb_hit, upd, vsel, lsel, nsel;
  usb_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk(ext_clk), .rst_n(reset_n), .req(req_valid), .en(state_q == IDLE),
    .upd(upd), .upd_idx(gidx_q), .gnt(arb_gnt), .gidx(arb_idx), .hit(arb_hit)
  );
  always_comb begin
    vsel = 1'b0;
    lsel = 1'b0;
    nsel = 1'b0;
    bsel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IW'(i)) begin
        vsel = req_valid[i];
        lsel = req_last[i];
        nsel = req_nodata[i];
        bsel = req_data[8*i +: 8];
      end
    end
  end
  assign req_ready         = (state_q == DATA) ? grant_q : '0;
  assign grant             = grant_q;
  assign pkt_done          = done_q;
  assign err_overlen       = ovl_q;
  assign err_ack_timeout   = tmo_q;
  assign buf_in_addr       = addr_q;
  assign buf_in_data       = data_q;
  assign buf_in_wren       = wren_q;
  assign buf_in_commit     = commit_q;
  assign buf_in_commit_len = len_q;
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tcnt_d   = tcnt_q;
    commit_d = commit_q;
    wren_d   = 1'b0;
    done_d   = 1'b0;
    ovl_d    = 1'b0;
    tmo_d    = 1'b0;
    upd      = 1'b0;
    ack_hi_d = ack_hi_q & buf_in_commit_ack;
    case (state_q)
      IDLE: if (arb_hit) begin
        grant_d = arb_gnt;
        gidx_d  = arb_idx;
        cnt_d   = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: if (buf_in_ready) state_d = DATA;
      DATA: if (vsel) begin
        if (lsel && nsel && cnt_q == '0) state_d = COMMIT;
        else begin
          wren_d = 1'b1;
          data_d = bsel;
          addr_d = cnt_q[BUF_ADDR_W-1:0];
          cnt_d  = cnt_q + 1'b1;
          if (lsel || cnt_q == BUF_LEN_W'(MAX_PKT - 1)) begin
            state_d = COMMIT;
            ovl_d   = !lsel;
          end
        end
      end
      // a level ack left high by the previous handshake must drop before a new commit
      COMMIT: if (!ack_hi_q) begin
        commit_d = 1'b1;
        len_d    = cnt_q;
        tcnt_d   = '0;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: if (buf_in_commit_ack) begin
        commit_d = 1'b0;
        done_d   = 1'b1;
        grant_d  = '0;
        upd      = 1'b1;
        ack_hi_d = 1'b1;
        state_d  = IDLE;
      end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
        commit_d = 1'b0;
        tmo_d    = 1'b1;
        grant_d  = '0;
        upd      = 1'b1;
        state_d  = IDLE;
      end else tcnt_d = tcnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ext_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tcnt_q   <= '0;
      commit_q <= 1'b0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
      ovl_q    <= 1'b0;
      tmo_q    <= 1'b0;
      ack_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      tcnt_q   <= tcnt_d;
      commit_q <= commit_d;
      wren_q   <= wren_d;
      done_q   <= done_d;
      ovl_q    <= ovl_d;
      tmo_q    <= tmo_d;
      ack_hi_q <= ack_hi_d;
    end
  end
endmodule

// File: tb/tb_usb_in_arbiter.sv
// tb_usb_in_arbiter: directed packet vectors plus multi-cycle corner sequences for usb_in_arbiter
module tb_usb_in_arbiter;
  localparam int N = 4;
  logic ext_clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_nodata = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic pkt_done, err_overlen, err_ack_timeout, buf_in_wren, buf_in_commit;
  logic buf_in_ready = 1'b1, buf_in_commit_ack = 1'b0;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic [9:0] buf_in_commit_len;
  always #5 ext_clk = ~ext_clk;
  usb_in_arbiter #(.NUM_REQ(N), .MAX_PKT(512), .ACK_TIMEOUT(1024)) dut (
    .ext_clk(ext_clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_nodata(req_nodata), .req_ready(req_ready), .grant(grant),
    .pkt_done(pkt_done), .err_overlen(err_overlen), .err_ack_timeout(err_ack_timeout),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack)
  );
  typedef struct packed {logic [7:0] d; logic l; logic n;} beat_t;
  typedef struct packed {logic [8:0] a; logic [7:0] d;} wr_t;
  typedef struct {int r; int n; logic [7:0] base; bit nod; int len; int nw;} vec_t;
  beat_t rq[N][$];
  wr_t wq[$];
  int cq[$];
  logic [N-1:0] gq[$];
  int glog[$];
  int checks, fails, done_n, ovl_n, tmo_n, chi, rdy_n, ackw;
  bit ack_en = 1'b1;
  logic cprev = 1'b0;
  logic [N-1:0] gprev = '0, hs = '0;
  always @(posedge ext_clk) hs <= req_valid & req_ready;
  always @(negedge ext_clk) begin
    for (int i = 0; i < N; i++) begin
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i] = rq[i].size() > 0;
      if (rq[i].size() > 0) begin
        req_data[8*i +: 8] = rq[i][0].d;
        req_last[i]        = rq[i][0].l;
        req_nodata[i]      = rq[i][0].n;
      end
    end
  end
  always @(negedge ext_clk) begin
    if (buf_in_commit && ack_en) begin
      ackw++;
      buf_in_commit_ack = (ackw == 3);
    end else begin
      ackw = 0;
      buf_in_commit_ack = 1'b0;
    end
  end
  always @(negedge ext_clk) begin
    if (buf_in_wren) wq.push_back({buf_in_addr, buf_in_data});
    if (buf_in_commit && !cprev) begin
      cq.push_back(int'(buf_in_commit_len));
      gq.push_back(grant);
    end
    if (grant != '0 && gprev == '0)
      for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
    cprev = buf_in_commit;
    gprev = grant;
    done_n += int'(pkt_done);
    ovl_n  += int'(err_overlen);
    tmo_n  += int'(err_ack_timeout);
    chi    += int'(buf_in_commit);
    rdy_n  += int'(req_ready != '0);
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge ext_clk);
      #1;
    end
  endtask
  task automatic clr();
    wq.delete(); cq.delete(); gq.delete(); glog.delete();
    done_n = 0; ovl_n = 0; tmo_n = 0; chi = 0; rdy_n = 0;
  endtask
  task automatic push(input int r, input int n, input logic [7:0] base, input bit nod);
    for (int k = 0; k < n; k++) rq[r].push_back({8'(base + k), k == n - 1, nod});
  endtask
  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_n < n && k < budget) begin
      cyc();
      k++;
    end
    if (done_n < n) chk("done_wait_expired", done_n, n);
  endtask
  function automatic int bad_seq(input int from, input int cnt, input logic [7:0] base);
    int bad = 0;
    for (int k = 0; k < cnt; k++)
      if (from + k >= wq.size()) bad++;
      else if (wq[from+k].a != 9'(k) || wq[from+k].d != 8'(base + k)) bad++;
    return bad;
  endfunction
  vec_t tv[6];
  int exp_g[5];
  logic [7:0] rr_base[5];
  int bad, k;
  initial begin
    tv[0] = '{0, 4,   8'hA0, 1'b0, 4,   4};
    tv[1] = '{1, 1,   8'h10, 1'b0, 1,   1};
    tv[2] = '{2, 1,   8'h00, 1'b1, 0,   0};
    tv[3] = '{3, 512, 8'h00, 1'b0, 512, 512};
    tv[4] = '{1, 3,   8'h70, 1'b1, 3,   3};
    tv[5] = '{3, 2,   8'hF0, 1'b0, 2,   2};
    exp_g   = '{0, 1, 2, 3, 0};
    rr_base = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
    cyc(3);
    chk("reset_outputs", {grant, req_ready, pkt_done, err_overlen, err_ack_timeout, buf_in_addr,
        buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len}, 0);
    reset_n = 1'b1;
    cyc(2);
    clr();
    for (int p = 0; p < 5; p++) push(p % N, 2, rr_base[p], 1'b0);
    wait_done(5, 300);
    cyc(2);
    chk("rr_grant_count", glog.size(), 5);
    bad = 0;
    for (int p = 0; p < 5; p++) if (p >= glog.size() || glog[p] != exp_g[p]) bad++;
    chk("rr_grant_order", bad, 0);
    bad = 0;
    for (int p = 0; p < 5; p++) bad += bad_seq(2 * p, 2, rr_base[p]);
    chk("rr_write_order", bad, 0);
    chk("rr_write_count", wq.size(), 10);
    for (int v = 0; v < 6; v++) begin
      clr();
      push(tv[v].r, tv[v].n, tv[v].base, tv[v].nod);
      wait_done(1, tv[v].n + 60);
      cyc(2);
      chk($sformatf("v%0d_len", v), cq.size() > 0 ? cq[0] : -1, tv[v].len);
      chk($sformatf("v%0d_commits", v), cq.size(), 1);
      chk($sformatf("v%0d_writes", v), wq.size(), tv[v].nw);
      chk($sformatf("v%0d_content", v), bad_seq(0, tv[v].nw, tv[v].base), 0);
      chk($sformatf("v%0d_overlen", v), ovl_n, 0);
      chk($sformatf("v%0d_done", v), done_n, 1);
      chk($sformatf("v%0d_owner", v), gq.size() > 0 ? gq[0] : '0, 1 << tv[v].r);
      chk($sformatf("v%0d_grant_idle", v), grant, 0);
    end
    clr();
    push(2, 600, 8'h00, 1'b0);
    wait_done(2, 800);
    cyc(2);
    chk("ovl_commits", cq.size(), 2);
    chk("ovl_len0", cq.size() > 0 ? cq[0] : -1, 512);
    chk("ovl_len1", cq.size() > 1 ? cq[1] : -1, 88);
    chk("ovl_pulses", ovl_n, 1);
    chk("ovl_writes", wq.size(), 600);
    chk("ovl_content", bad_seq(0, 512, 8'h00) + bad_seq(512, 88, 8'h00), 0);
    clr();
    buf_in_ready = 1'b0;
    push(1, 2, 8'h55, 1'b0);
    cyc(50);
    chk("rdy_low_grant", grant, 4'b0010);
    chk("rdy_low_ready", rdy_n, 0);
    chk("rdy_low_writes", wq.size(), 0);
    buf_in_ready = 1'b1;
    wait_done(1, 40);
    cyc(2);
    chk("rdy_len", cq.size() > 0 ? cq[0] : -1, 2);
    chk("rdy_content", bad_seq(0, 2, 8'h55), 0);
    clr();
    ack_en = 1'b0;
    push(2, 1, 8'h99, 1'b0);
    k = 0;
    while (tmo_n < 1 && k < 1200) begin
      cyc();
      k++;
    end
    cyc(2);
    chk("tmo_pulses", tmo_n, 1);
    chk("tmo_commit_cycles", chi, 1024);
    chk("tmo_done", done_n, 0);
    chk("tmo_commit_low", buf_in_commit, 0);
    chk("tmo_grant", grant, 0);
    ack_en = 1'b1;
    clr();
    push(3, 10, 8'hC0, 1'b0);
    k = 0;
    while (wq.size() < 3 && k < 50) begin
      cyc();
      k++;
    end
    chk("rst_mid_writes", wq.size(), 3);
    reset_n = 1'b0;
    #1;
    chk("rst_async_outs", {grant, buf_in_wren, buf_in_addr, buf_in_data, buf_in_commit}, 0);
    cyc(2);
    rq[3].delete();
    cyc(2);
    reset_n = 1'b1;
    cyc();
    clr();
    push(3, 5, 8'hD0, 1'b0);
    wait_done(1, 80);
    cyc(2);
    chk("rst_fresh_len", cq.size() > 0 ? cq[0] : -1, 5);
    chk("rst_fresh_commits", cq.size(), 1);
    chk("rst_fresh_content", bad_seq(0, 5, 8'hD0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/usb_in_arbiter.md
Name: usb_in_arbiter

Overview:
Shares the single USB bulk-IN endpoint buffer port (buf_in_*) of the USB core among NUM_REQ byte-stream packet sources. A round-robin arbiter grants one requester at a time. The block streams that requester's packet into the endpoint buffer at incrementing addresses, then runs the commit/commit_ack handshake with the byte count. It sits between application data producers and the USB core top-level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_PKT, 512, maximum bytes per committed packet (≤512; buffer address is 9 bits)
ACK_TIMEOUT, 1024, cycles to wait for buf_in_commit_ack before abort

Ports:
ext_clk  in  1  single clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i]
req_last  in  NUM_REQ  marks final beat of a packet
req_nodata  in  NUM_REQ  with valid&last on first beat: zero-length packet, no byte written
req_ready  out  NUM_REQ  beat accepted when valid&ready
grant  out  NUM_REQ  one-hot current owner; 0 when idle
pkt_done  out  1  one-cycle pulse: commit acknowledged
err_overlen  out  1  one-cycle pulse: packet truncated at MAX_PKT
err_ack_timeout  out  1  one-cycle pulse: commit not acknowledged
buf_in_addr  out  9  endpoint buffer write address
buf_in_data  out  8  endpoint buffer write data
buf_in_wren  out  1  endpoint buffer write strobe
buf_in_ready  in  1  USB core can accept a new packet
buf_in_commit  out  1  commit request, level
buf_in_commit_len  out  10  committed byte count, 0..MAX_PKT
buf_in_commit_ack  in  1  commit accepted (pulse or level)

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer = 0; byte count = 0; timeout counter = 0. An assertion at any point mid-operation aborts the packet immediately. No commit is issued, and requesters must restart the packet.
- States: IDLE, WAIT_RDY, DATA, COMMIT, WAIT_ACK.
- IDLE:
  - The arbiter considers requesters with req_valid = 1, searching round-robin from (last winner + 1) mod NUM_REQ.
  - On a hit, grant is registered next cycle and the state goes to WAIT_RDY.
  - No grant changes mid-packet.
- WAIT_RDY: hold grant; go to DATA when buf_in_ready = 1.
- DATA:
  - req_ready[g] = 1 combinationally while in DATA; all other req_ready = 0.
  - Each accepted beat registers buf_in_data = byte, buf_in_addr = count, buf_in_wren = 1 on the following cycle (1-cycle latency). count increments.
  - The packet ends on an accepted beat with req_last = 1, or when count reaches MAX_PKT−1 on an accepted beat.
  - Forced end at MAX_PKT: err_overlen pulses if req_last = 0. Remaining bytes from that requester form a new packet after re-arbitration.
  - First beat with valid & last & nodata: no write, count stays 0. req_nodata is ignored on any later beat.
  - End of packet goes to COMMIT.
- COMMIT: one cycle after the final write. buf_in_commit = 1 and buf_in_commit_len = final count, both held stable. Go to WAIT_ACK.
- WAIT_ACK:
  - Hold commit and len.
  - On buf_in_commit_ack = 1: deassert commit next cycle, pulse pkt_done, record winner, clear grant, return to IDLE.
  - If the timeout counter reaches ACK_TIMEOUT−1 with no ack: deassert commit, pulse err_ack_timeout, return to IDLE.
  - The counter clears on entry to WAIT_ACK.
- A level-type ack stays high after the handshake. The arbiter does not re-enter COMMIT until it has observed buf_in_commit_ack = 0.
- Width rules:
  - count is 10 bits; buf_in_addr = count[8:0].
  - MAX_PKT = 512 yields commit_len = 10'd512 with addresses 0..511. No wrap.
- Simultaneous requests are resolved by the round-robin pointer only. A requester that deasserts req_valid before grant loses the slot without penalty.
- req_valid deasserted mid-packet inserts idle cycles in DATA; there is no timeout on data.

Decomposition:
- Shared package usb_arb_pkg:
  - state enumeration
  - constants BUF_ADDR_W = 9, BUF_LEN_W = 10
  - function for round-robin next-index
- One sub-module, usb_rr_arbiter:
  - inputs: request vector, pointer, enable
  - output: one-hot grant
  - combinational search plus registered pointer update on pkt_done or abort

Test Plan:
- Single requester, 4 bytes 0xA0..0xA3 with last on the 4th: writes at addr 0..3, commit_len = 4, ack after 3 cycles → pkt_done one pulse, grant returns to 0.
- All 4 requesters valid at once, each sending a 2-byte packet: grants in order 0,1,2,3, then 0 again; no interleaved bytes between packets.
- Requester 2 streams 600 bytes with no last: commit_len = 512, err_overlen pulses once, and the next 88 bytes arrive as a separate packet with commit_len = 88.
- Zero-length packet (valid & last & nodata): no buf_in_wren, commit_len = 0, pkt_done pulses.
- buf_in_ready low for 50 cycles after grant: no req_ready and no writes until ready rises. Separately, ack withheld for 1024 cycles → err_ack_timeout pulses, commit drops.
- reset_n asserted in DATA after 3 bytes: all outputs 0 asynchronously; after release, a fresh packet from the same requester commits with its correct length.
